// File: rtl/pe_mac.sv
// Systolic-array processing element: forwards activation/weight to its east/south neighbours
// and accumulates a signed dot product through a registered multiply stage.
module pe_mac #(
    parameter int DATA_W   = 8,
    parameter int WGT_W    = 8,
    parameter int ACC_W    = 32,
    parameter int SIGN_MAG = 1,
    parameter int SAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              last_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [WGT_W-1:0]  weight_in,
    output logic [DATA_W-1:0] data_out,
    output logic [WGT_W-1:0]  weight_out,
    output logic              out_valid,
    output logic              last_out,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    output logic              ovf
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [WGT_W-1:0]    weight_q, weight_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [ACC_W-1:0]    prod_q, prod_d;
    logic                prod_v_q, prod_v_d;
    logic                prod_last_q, prod_last_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic                sum_valid_q, sum_valid_d;
    logic                ovf_q, ovf_d;

    logic signed [ACC_W-1:0] prod_calc;
    logic signed [ACC_W:0]   base_ext;
    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic                    ovf_now;
    logic [ACC_W-1:0]        result;

    generate
        if (SIGN_MAG != 0) begin : g_sign_mag
            // Negating a zero magnitude yields zero, so -0 needs no special case.
            localparam int MAG_W = DATA_W + WGT_W - 2;
            logic [MAG_W-1:0]        mag;
            logic signed [ACC_W-1:0] mag_ext;
            assign mag       = MAG_W'(data_in[DATA_W-2:0]) * MAG_W'(weight_in[WGT_W-2:0]);
            assign mag_ext   = $signed(ACC_W'(mag));
            assign prod_calc = (data_in[DATA_W-1] ^ weight_in[WGT_W-1]) ? -mag_ext : mag_ext;
        end else begin : g_twos
            logic signed [DATA_W+WGT_W-1:0] p_full;
            assign p_full    = $signed(data_in) * $signed(weight_in);
            assign prod_calc = ACC_W'(p_full);
        end
    endgenerate

    // One guard bit: a sign mismatch between the top two bits means the ACC_W range was left.
    always_comb begin
        base_ext = (state_q == ST_ACC) ? {acc_q[ACC_W-1], acc_q} : '0;
        prod_ext = {prod_q[ACC_W-1], prod_q};
        sum_wide = base_ext + prod_ext;
        ovf_now  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (ovf_now && (SAT != 0)) begin
            result = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            result = sum_wide[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        weight_d    = weight_q;
        valid_d     = valid_q;
        last_d      = last_q;
        prod_d      = prod_q;
        prod_v_d    = prod_v_q;
        prod_last_d = prod_last_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        ovf_d       = ovf_q;

        if (en) begin
            data_d      = data_in;
            weight_d    = weight_in;
            valid_d     = in_valid;
            last_d      = last_in;
            prod_d      = prod_calc;
            prod_v_d    = in_valid;
            prod_last_d = in_valid & last_in;
            if (prod_v_q) begin
                acc_d = result;
                ovf_d = ovf_q | ovf_now;
                if (prod_last_q) begin
                    sum_d       = result;
                    sum_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ACC;
                end
            end
        end

        // Abort wins over everything in the accumulate path but leaves sum and forwarding alone.
        if (clr) begin
            acc_d       = '0;
            state_d     = ST_IDLE;
            prod_v_d    = 1'b0;
            prod_last_d = 1'b0;
            ovf_d       = 1'b0;
            sum_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            weight_q    <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            prod_last_q <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            weight_q    <= weight_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            prod_last_q <= prod_last_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign data_out   = data_q;
    assign weight_out = weight_q;
    assign out_valid  = valid_q;
    assign last_out   = last_q;
    assign sum        = sum_q;
    assign sum_valid  = sum_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_pe_mac.sv
// Bench for pe_mac: four parameterisations share one stimulus stream; a behavioural
// model pushes expected sums per instance and a negedge monitor pops them on each sum_valid.
module tb_pe_mac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       last_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] weight_in = '0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: two's complement; 2: ACC_W=16 saturating; 3: ACC_W=16 wrapping.
    longint     sum_obs [4];
    logic       sv [4];
    logic       ov [4];
    logic [7:0] dout [4];
    logic [7:0] wout [4];
    logic       vout [4];
    logic       lout [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            localparam int AW = (gi >= 2) ? 16 : 32;
            logic [AW-1:0] s;
            logic [7:0]    d_o;
            logic [7:0]    w_o;
            logic          v_o;
            logic          l_o;
            logic          sv_o;
            logic          ov_o;
            pe_mac #(
                .DATA_W   (8),
                .WGT_W    (8),
                .ACC_W    (AW),
                .SIGN_MAG ((gi == 1) ? 0 : 1),
                .SAT      ((gi == 3) ? 0 : 1)
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en),
                .clr        (clr),
                .in_valid   (in_valid),
                .last_in    (last_in),
                .data_in    (data_in),
                .weight_in  (weight_in),
                .data_out   (d_o),
                .weight_out (w_o),
                .out_valid  (v_o),
                .last_out   (l_o),
                .sum        (s),
                .sum_valid  (sv_o),
                .ovf        (ov_o)
            );
            assign sum_obs[gi] = longint'($signed(s));
            assign sv[gi]      = sv_o;
            assign ov[gi]      = ov_o;
            assign dout[gi]    = d_o;
            assign wout[gi]    = w_o;
            assign vout[gi]    = v_o;
            assign lout[gi]    = l_o;
        end
    endgenerate

    int     n_vec = 0;
    int     n_err = 0;
    longint exp_q [4][$];
    longint acc_m [4];
    bit     indp_m [4];
    bit     ovf_m [4];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int aw_of(input int i);
        return (i >= 2) ? 16 : 32;
    endfunction

    function automatic longint mprod(input int i, input logic [7:0] d, input logic [7:0] w);
        longint m;
        if (i != 1) begin
            m = longint'(d[6:0]) * longint'(w[6:0]);
            return (d[7] ^ w[7]) ? -m : m;
        end
        return longint'($signed(d)) * longint'($signed(w));
    endfunction

    task automatic model_add(input logic [7:0] d, input logic [7:0] w, input logic l);
        longint x, mx, mn, mask;
        for (int i = 0; i < 4; i++) begin
            mx = (64'sd1 <<< (aw_of(i) - 1)) - 1;
            mn = -mx - 1;
            mask = (64'sd1 <<< aw_of(i)) - 1;
            x = (indp_m[i] ? acc_m[i] : 64'sd0) + mprod(i, d, w);
            if (x > mx || x < mn) begin
                ovf_m[i] = 1'b1;
                if (i != 3) begin
                    x = (x > mx) ? mx : mn;
                end else begin
                    x = x & mask;
                    if (x > mx) x = x - (mask + 1);
                end
            end
            acc_m[i] = x;
            if (l) begin
                exp_q[i].push_back(x);
                indp_m[i] = 1'b0;
            end else begin
                indp_m[i] = 1'b1;
            end
        end
    endtask

    task automatic model_clear(input bit drop_pending);
        for (int i = 0; i < 4; i++) begin
            acc_m[i] = 0;
            indp_m[i] = 1'b0;
            ovf_m[i] = 1'b0;
            if (drop_pending) exp_q[i].delete();
        end
    endtask

    task automatic pair(input logic [7:0] d, input logic [7:0] w, input logic l);
        @(negedge clk);
        en = 1'b1; clr = 1'b0; in_valid = 1'b1; last_in = l; data_in = d; weight_in = w;
        model_add(d, w, l);
        @(posedge clk); #1;
        chk("fwd_data", longint'(dout[1]), longint'(d));
        chk("fwd_wgt", longint'(wout[1]), longint'(w));
        chk("fwd_valid", longint'(vout[1]), 1);
        chk("fwd_last", longint'(lout[1]), longint'(l));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en = 1'b1; clr = 1'b0; in_valid = 1'b0;
            last_in = 1'($urandom); data_in = 8'($urandom); weight_in = 8'($urandom);
            @(posedge clk); #1;
            chk("fwd_bubble", longint'(vout[1]), 0);
        end
    endtask

    task automatic stall(input int n);
        logic [7:0] hold;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            hold = dout[1];
            en = 1'b0; clr = 1'b0; in_valid = 1'b1; last_in = 1'b1;
            data_in = 8'($urandom); weight_in = 8'($urandom);
            @(posedge clk); #1;
            chk("stall_fwd_hold", longint'(dout[1]), longint'(hold));
        end
    endtask

    task automatic do_clr();
        logic [7:0] hold;
        @(negedge clk);
        hold = dout[1];
        en = 1'b0; clr = 1'b1; in_valid = 1'b1; last_in = 1'b1;
        data_in = 8'($urandom); weight_in = 8'($urandom);
        model_clear(1'b0);
        @(posedge clk); #1;
        chk("clr_fwd_hold", longint'(dout[1]), longint'(hold));
    endtask

    task automatic ovf_all();
        for (int i = 0; i < 4; i++) chk($sformatf("ovf%0d", i), longint'(ov[i]), longint'(ovf_m[i]));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (sv[i]) begin
                    if (exp_q[i].size() == 0) chk($sformatf("unexpected_pulse%0d", i), 0, 1);
                    else chk($sformatf("sum%0d", i), sum_obs[i], exp_q[i].pop_front());
                end
            end
        end
    end

    initial begin
        int len;
        model_clear(1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", sum_obs[0], 0);
        chk("rst_sum_valid", longint'(sv[0]), 0);
        chk("rst_ovf", longint'(ov[2]), 0);
        chk("rst_out_valid", longint'(vout[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sign-magnitude dot product and its latency
        pair(8'h83, 8'h05, 1'b0);
        pair(8'h02, 8'h04, 1'b0);
        pair(8'h81, 8'h81, 1'b1);
        chk("lat_edge1", longint'(sv[0]), 0);
        idle(1);
        chk("lat_edge2", longint'(sv[0]), 1);
        chk("sm_dot", sum_obs[0], -6);
        idle(1);
        chk("single_pulse", longint'(sv[0]), 0);
        chk("sum_hold", sum_obs[0], -6);
        ovf_all();

        // Two's complement dot product
        pair(8'hFD, 8'h05, 1'b0);
        pair(8'h80, 8'h80, 1'b1);
        idle(2);
        chk("tc_dot", sum_obs[1], 16369);

        // Overflow: saturate vs wrap, then clear
        pair(8'h7F, 8'h7F, 1'b0);
        pair(8'h7F, 8'h7F, 1'b0);
        pair(8'h7F, 8'h7F, 1'b1);
        idle(2);
        chk("sat_dot", sum_obs[2], 32767);
        chk("wrap_dot", sum_obs[3], -17149);
        ovf_all();
        do_clr();
        chk("clr_sum_keep", sum_obs[2], 32767);
        ovf_all();

        // Stalls and bubbles must not change the result
        pair(8'h83, 8'h05, 1'b0);
        stall(3);
        pair(8'h02, 8'h04, 1'b0);
        idle(2);
        pair(8'h81, 8'h81, 1'b1);
        idle(2);
        chk("stall_dot", sum_obs[0], -6);

        // Abort mid dot product, then a fresh one
        pair(8'h7F, 8'h7F, 1'b0);
        idle(1);
        do_clr();
        idle(2);
        pair(8'h02, 8'h04, 1'b0);
        pair(8'h83, 8'h05, 1'b1);
        idle(2);
        chk("post_clr_dot", sum_obs[0], -7);

        // Random dot products with bubbles and stalls
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                pair(8'($urandom), 8'($urandom), (k == len - 1));
                if ($urandom_range(0, 2) == 0) idle(1);
                if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 2));
            end
        end
        idle(3);
        ovf_all();

        // Asynchronous reset while holding a partial sum
        pair(8'h85, 8'h03, 1'b0);
        pair(8'h04, 8'h04, 1'b0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", sum_obs[0], 0);
        chk("arst_sum_valid", longint'(sv[0]), 0);
        chk("arst_data_out", longint'(dout[1]), 0);
        chk("arst_weight_out", longint'(wout[1]), 0);
        chk("arst_out_valid", longint'(vout[1]), 0);
        chk("arst_ovf", longint'(ov[3]), 0);
        model_clear(1'b1);
        #1;
        rst_n = 1'b1;
        pair(8'h85, 8'h03, 1'b1);
        idle(2);
        chk("post_rst_dot", sum_obs[0], -15);

        for (int i = 0; i < 4; i++) chk($sformatf("pending%0d", i), exp_q[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
